// File: rtl/rx_prbs_ber_checker.sv
// Receive-side PRBS aligner and BER counter: steps the reference delay tap until a window matches, then locks and counts.
// Latency: o_exor/counters update one cycle after the sampled valid; no backpressure, i_valid is a symbol strobe.
module rx_prbs_ber_checker #(
  parameter int NB_COUNT   = 64,
  parameter int NB_DELAY   = 9,
  parameter int MAX_DELAY  = 511,
  parameter int SEARCH_LEN = 511,
  parameter int LOCK_THR   = 0,
  parameter int LOSS_THR   = 64
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic                i_rx_bit,
  input  logic                i_ref_bit,
  output logic                o_lock,
  output logic [NB_DELAY-1:0] o_delay,
  output logic [NB_COUNT-1:0] o_bit_count,
  output logic [NB_COUNT-1:0] o_err_count,
  output logic                o_exor,
  output logic                o_search_fail
);
  localparam int NB_WIN = $clog2(SEARCH_LEN + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]          state;
  logic [MAX_DELAY-1:0] refLine;
  logic [MAX_DELAY:0]  taps;
  logic [NB_WIN-1:0]   winCnt;
  logic [NB_WIN-1:0]   winErr;
  logic [NB_WIN-1:0]   winErrNext;
  logic [NB_WIN:0]     winTot;
  logic                mis;
  logic                winEnd;
  logic                lockHit;
  logic                lossHit;
  logic                wrap;
  logic [NB_DELAY-1:0] delayNext;
  logic [NB_COUNT-1:0] bitNext;
  logic [NB_COUNT-1:0] errNext;

  // Tap 0 is the live reference bit; tap k is the bit seen k valids ago.
  assign taps = {refLine, i_ref_bit};
  assign mis  = i_rx_bit ^ taps[o_delay];

  // Window decisions include the mismatch of the valid being sampled.
  assign winTot     = {1'b0, winErr} + {{NB_WIN{1'b0}}, mis};
  assign winErrNext = (int'(winTot) > SEARCH_LEN) ? NB_WIN'(SEARCH_LEN) : winTot[NB_WIN-1:0];
  assign winEnd     = (winCnt == NB_WIN'(SEARCH_LEN - 1));
  assign lockHit    = (int'(winTot) <= LOCK_THR);
  assign lossHit    = (int'(winTot) > LOSS_THR);

  assign wrap      = (o_delay == NB_DELAY'(MAX_DELAY));
  assign delayNext = wrap ? '0 : o_delay + NB_DELAY'(1);

  assign bitNext = (&o_bit_count) ? o_bit_count : o_bit_count + NB_COUNT'(1);
  assign errNext = (mis && !(&o_err_count)) ? o_err_count + NB_COUNT'(1) : o_err_count;

  assign o_lock = (state == LOCKED);

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state         <= IDLE;
      refLine       <= '0;
      o_delay       <= '0;
      winCnt        <= '0;
      winErr        <= '0;
      o_bit_count   <= '0;
      o_err_count   <= '0;
      o_exor        <= 1'b0;
      o_search_fail <= 1'b0;
    end else begin
      if (i_valid) begin
        refLine <= taps[MAX_DELAY-1:0];
        o_exor  <= mis;
      end

      if (i_enable && i_valid && state != IDLE) begin
        winCnt <= winEnd ? '0 : winCnt + NB_WIN'(1);
        winErr <= winEnd ? '0 : winErrNext;
      end

      if (!i_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            state         <= SEARCH;
            o_delay       <= '0;
            winCnt        <= '0;
            winErr        <= '0;
            o_search_fail <= 1'b0;
          end
          SEARCH: begin
            if (i_valid && winEnd) begin
              if (lockHit) begin
                state       <= LOCKED;
                o_bit_count <= '0;
                o_err_count <= '0;
              end else begin
                o_delay <= delayNext;
                if (wrap) o_search_fail <= 1'b1;
              end
            end
          end
          LOCKED: begin
            if (i_valid) begin
              // Losing lock freezes the counters on the deciding valid.
              if (winEnd && lossHit) begin
                state   <= SEARCH;
                o_delay <= delayNext;
                if (wrap) o_search_fail <= 1'b1;
              end else begin
                o_bit_count <= bitNext;
                o_err_count <= errNext;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_prbs_ber_checker.sv
// Bench for rx_prbs_ber_checker: a full-size instance (A) and a small NB_COUNT=4 / MAX_DELAY=7 / SEARCH_LEN=32 instance (B)
// driven by PRBS9 streams and compared every cycle against a window-level reference model.
module tb_rx_prbs_ber_checker;
  localparam int IDLE_M   = 0;
  localparam int SEARCH_M = 1;
  localparam int LOCK_M   = 2;
  localparam int HIST     = 16384;

  logic clock = 1'b0;
  logic i_reset;
  logic en [2];
  logic vld [2];
  logic rx [2];
  logic rf [2];

  logic        lockA, exorA, sfailA;
  logic [8:0]  delayA;
  logic [63:0] bitsA, errsA;
  logic        lockB, exorB, sfailB;
  logic [2:0]  delayB;
  logic [3:0]  bitsB, errsB;

  int checks   = 0;
  int failures = 0;

  // Reference model state, one slot per instance.
  int          mMode [2];
  int          mDelay [2];
  int          mWcnt [2];
  int          mWerr [2];
  bit          mSfail [2];
  bit          mExor [2];
  logic [63:0] mBits [2];
  logic [63:0] mErrs [2];
  int          nRef [2];
  bit          refStream [2][HIST];
  logic [8:0]  lfsr [2];

  always #5 clock = ~clock;

  rx_prbs_ber_checker u_big (
    .clock(clock), .i_reset(i_reset), .i_enable(en[0]), .i_valid(vld[0]),
    .i_rx_bit(rx[0]), .i_ref_bit(rf[0]), .o_lock(lockA), .o_delay(delayA),
    .o_bit_count(bitsA), .o_err_count(errsA), .o_exor(exorA), .o_search_fail(sfailA)
  );

  rx_prbs_ber_checker #(
    .NB_COUNT(4), .NB_DELAY(3), .MAX_DELAY(7), .SEARCH_LEN(32), .LOCK_THR(0), .LOSS_THR(24)
  ) u_small (
    .clock(clock), .i_reset(i_reset), .i_enable(en[1]), .i_valid(vld[1]),
    .i_rx_bit(rx[1]), .i_ref_bit(rf[1]), .o_lock(lockB), .o_delay(delayB),
    .o_bit_count(bitsB), .o_err_count(errsB), .o_exor(exorB), .o_search_fail(sfailB)
  );

  function automatic int pLen(input int id);  return (id == 0) ? 511 : 32; endfunction
  function automatic int pMax(input int id);  return (id == 0) ? 511 : 7;  endfunction
  function automatic int pLoss(input int id); return (id == 0) ? 64 : 24;  endfunction
  function automatic logic [63:0] pCmax(input int id);
    return (id == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd15;
  endfunction

  // Reference bit presented k valids before the current one (zero before reset history).
  function automatic bit pastRef(input int id, input int k);
    int idx;
    idx = nRef[id] - k;
    return (idx >= 0 && idx < HIST) ? refStream[id][idx] : 1'b0;
  endfunction

  task automatic modelReset(input int id);
    mMode[id] = IDLE_M; mDelay[id] = 0; mWcnt[id] = 0; mWerr[id] = 0;
    mSfail[id] = 1'b0; mExor[id] = 1'b0; mBits[id] = '0; mErrs[id] = '0; nRef[id] = 0;
  endtask

  task automatic bumpDelay(input int id);
    if (mDelay[id] == pMax(id)) begin
      mDelay[id] = 0;
      mSfail[id] = 1'b1;
    end else begin
      mDelay[id] = mDelay[id] + 1;
    end
  endtask

  task automatic modelEdge(input int id, input bit e, input bit v, input bit r, input bit f);
    bit tap, mis, wend;
    int tot;
    tap  = (mDelay[id] == 0) ? f : pastRef(id, mDelay[id]);
    mis  = r ^ tap;
    tot  = mWerr[id] + int'(mis);
    if (tot > pLen(id)) tot = pLen(id);
    wend = (mWcnt[id] == pLen(id) - 1);
    if (v) mExor[id] = mis;
    if (!e) begin
      mMode[id] = IDLE_M;
    end else if (mMode[id] == IDLE_M) begin
      mMode[id] = SEARCH_M; mDelay[id] = 0; mWcnt[id] = 0; mWerr[id] = 0; mSfail[id] = 1'b0;
    end else if (v) begin
      if (mMode[id] == SEARCH_M && wend) begin
        if (tot <= 0) begin
          mMode[id] = LOCK_M; mBits[id] = '0; mErrs[id] = '0;
        end else begin
          bumpDelay(id);
        end
      end else if (mMode[id] == LOCK_M && wend && tot > pLoss(id)) begin
        mMode[id] = SEARCH_M;
        bumpDelay(id);
      end else if (mMode[id] == LOCK_M) begin
        if (mBits[id] != pCmax(id)) mBits[id] = mBits[id] + 64'd1;
        if (mis && mErrs[id] != pCmax(id)) mErrs[id] = mErrs[id] + 64'd1;
      end
      if (wend) begin
        mWcnt[id] = 0; mWerr[id] = 0;
      end else begin
        mWcnt[id] = mWcnt[id] + 1; mWerr[id] = tot;
      end
    end
    if (v && nRef[id] < HIST) begin
      refStream[id][nRef[id]] = f;
      nRef[id] = nRef[id] + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("A_lock",  64'(lockA),  64'(mMode[0] == LOCK_M));
    chk("A_delay", 64'(delayA), 64'(mDelay[0]));
    chk("A_bits",  bitsA,       mBits[0]);
    chk("A_errs",  errsA,       mErrs[0]);
    chk("A_exor",  64'(exorA),  64'(mExor[0]));
    chk("A_sfail", 64'(sfailA), 64'(mSfail[0]));
    chk("B_lock",  64'(lockB),  64'(mMode[1] == LOCK_M));
    chk("B_delay", 64'(delayB), 64'(mDelay[1]));
    chk("B_bits",  64'(bitsB),  mBits[1]);
    chk("B_errs",  64'(errsB),  mErrs[1]);
    chk("B_exor",  64'(exorB),  64'(mExor[1]));
    chk("B_sfail", 64'(sfailB), 64'(mSfail[1]));
  endtask

  task automatic tick();
    @(posedge clock);
    for (int id = 0; id < 2; id++) begin
      if (i_reset) modelReset(id);
      else modelEdge(id, en[id], vld[id], rx[id], rf[id]);
    end
    #1;
    checkAll();
  endtask

  task automatic prbsNext(input int id, output logic b);
    b = lfsr[id][8] ^ lfsr[id][4];
    lfsr[id] = {lfsr[id][7:0], b};
  endtask

  // One valid on instance id after gap idle clocks; rx is the reference delayed by 5 valids, or held at 1.
  task automatic sendBit(input int id, input bit inv, input bit useOnes, input int gap);
    logic b;
    for (int g = 0; g < gap; g++) tick();
    prbsNext(id, b);
    rf[id]  = b;
    rx[id]  = (useOnes ? 1'b1 : logic'(pastRef(id, 5))) ^ inv;
    vld[id] = 1'b1;
    tick();
    vld[id] = 1'b0;
  endtask

  initial begin
    int lockIdx;
    bit flag;
    for (int id = 0; id < 2; id++) begin
      en[id] = 1'b0; vld[id] = 1'b0; rx[id] = 1'b0; rf[id] = 1'b0;
      lfsr[id] = 9'($urandom_range(1, 511));
      modelReset(id);
    end
    i_reset = 1'b1;
    #3;
    checkAll();
    tick();
    tick();
    i_reset = 1'b0;
    tick();

    // Aligned search on the full-size instance, valid every 8 clocks.
    en[0] = 1'b1;
    tick();
    lockIdx = -1;
    for (int i = 1; i <= 3200 && lockIdx < 0; i++) begin
      sendBit(0, 1'b0, 1'b0, 7);
      if (lockA === 1'b1) lockIdx = i;
    end
    chk("t1_lock_valid", 64'(lockIdx), 64'd3066);
    chk("t1_delay", 64'(delayA), 64'd5);
    chk("t1_sfail", 64'(sfailA), 64'd0);
    chk("t1_errs", errsA, 64'd0);

    // Every 100th bit inverted while locked, random valid spacing.
    flag = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      sendBit(0, (i % 100) == 99, 1'b0, int'($urandom_range(0, 1)));
      if (lockA !== 1'b1) flag = 1'b1;
    end
    chk("t2_bits", bitsA, 64'd10000);
    chk("t2_errs", errsA, 64'd100);
    chk("t2_lock_held", 64'(flag), 64'd0);

    // A full window of inverted data drops lock and moves to the next tap.
    for (int i = 0; i < 511; i++) sendBit(0, 1'b1, 1'b0, 0);
    chk("t3_lock", 64'(lockA), 64'd0);
    chk("t3_delay", 64'(delayA), 64'd6);

    // Small instance: lock, saturate, lose lock, reacquire through a wrap.
    en[1] = 1'b1;
    tick();
    lockIdx = -1;
    for (int i = 1; i <= 300 && lockIdx < 0; i++) begin
      sendBit(1, 1'b0, 1'b0, 0);
      if (lockB === 1'b1) lockIdx = i;
    end
    chk("t5_lock_valid", 64'(lockIdx), 64'd192);
    for (int i = 0; i < 20; i++) sendBit(1, 1'b1, 1'b0, 0);
    chk("t5_bits_sat", 64'(bitsB), 64'd15);
    chk("t5_errs_sat", 64'(errsB), 64'd15);
    chk("t5_lock", 64'(lockB), 64'd1);
    for (int i = 0; i < 12; i++) sendBit(1, 1'b1, 1'b0, 0);
    chk("t3s_lock", 64'(lockB), 64'd0);
    chk("t3s_delay", 64'(delayB), 64'd6);
    chk("t3s_bits_frozen", 64'(bitsB), 64'd15);
    lockIdx = -1;
    for (int i = 1; i <= 400 && lockIdx < 0; i++) begin
      sendBit(1, 1'b0, 1'b0, 0);
      if (lockB === 1'b1) lockIdx = i;
    end
    chk("t3s_relock_valid", 64'(lockIdx), 64'd256);
    chk("t3s_relock_delay", 64'(delayB), 64'd5);
    chk("t3s_sfail", 64'(sfailB), 64'd1);

    // Enable drop while locked: IDLE next edge, the coincident valid is not counted.
    for (int i = 0; i < 3; i++) sendBit(1, 1'b0, 1'b0, 0);
    en[1] = 1'b0;
    sendBit(1, 1'b1, 1'b0, 0);
    chk("t6_lock", 64'(lockB), 64'd0);
    chk("t6_bits", 64'(bitsB), 64'd3);
    chk("t6_errs", 64'(errsB), 64'd0);
    chk("t6_delay", 64'(delayB), 64'd5);

    // No correlation: rx held high through every tap.
    en[1] = 1'b1;
    tick();
    chk("t4_sfail_clr", 64'(sfailB), 64'd0);
    chk("t4_delay_clr", 64'(delayB), 64'd0);
    flag = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sendBit(1, 1'b0, 1'b1, 0);
      if (lockB !== 1'b0) flag = 1'b1;
    end
    chk("t4_never_lock", 64'(flag), 64'd0);
    chk("t4_delay_wrap", 64'(delayB), 64'd0);
    chk("t4_sfail", 64'(sfailB), 64'd1);

    // Asynchronous reset mid-window, observed before any clock edge.
    for (int i = 0; i < 10; i++) sendBit(1, 1'b0, 1'b1, 0);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_lockA", 64'(lockA), 64'd0);
    chk("rst_delayA", 64'(delayA), 64'd0);
    chk("rst_bitsA", bitsA, 64'd0);
    chk("rst_errsA", errsA, 64'd0);
    chk("rst_sfailB", 64'(sfailB), 64'd0);
    chk("rst_bitsB", 64'(bitsB), 64'd0);
    for (int id = 0; id < 2; id++) modelReset(id);
    checkAll();
    #1;
    i_reset = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
